// File: rtl/inst_mem_fetch.sv
// Registered instruction memory for the IF stage: valid/ready fetch port with
// fault reporting, flush and back-pressure, plus a word-wide run-time programming port.
module inst_mem_fetch #(
    parameter int          DEPTH     = 64,
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_inst,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_fault,
    input  logic              flush,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [IDX_W-1:0]  prog_addr,
    input  logic [31:0]       prog_data
);

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    // Power-up contents are NOPs; reset deliberately leaves the array alone.
    logic [31:0] mem_q [DEPTH] = '{default: NOP_INSTR};

    logic              valid_q, valid_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              fault_q, fault_d;

    logic [IDX_W-1:0]  req_idx;
    logic              req_in_range;
    logic              req_misaligned;
    logic              req_fault;
    logic              accept;
    logic              prog_in_range;

    assign req_idx        = req_addr[IDX_W+1:2];
    assign req_in_range   = ~|req_addr[ADDR_W-1:IDX_W+2];
    assign req_misaligned = |req_addr[1:0];
    assign req_fault      = req_misaligned | ~req_in_range;

    // Depends only on state and control inputs, never on the request itself.
    assign req_ready = !rst && !prog_en && (!valid_q || resp_ready || flush);
    assign accept    = req_valid && req_ready;

    assign prog_in_range = {1'b0, prog_addr} < DEPTH_L;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        addr_d  = addr_q;
        fault_d = fault_q;
        if (accept) begin
            valid_d = 1'b1;
            addr_d  = req_addr;
            fault_d = req_fault;
            inst_d  = req_fault ? NOP_INSTR : mem_q[req_idx];
        end else if (valid_q && (resp_ready || flush)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INSTR;
            addr_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
            fault_q <= fault_d;
        end
    end

    // Writes proceed even during reset so a program load is never lost.
    always_ff @(posedge clk) begin
        if (prog_en && prog_we && prog_in_range) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign resp_valid = valid_q;
    assign resp_inst  = inst_q;
    assign resp_addr  = addr_q;
    assign resp_fault = fault_q;

endmodule

// File: doc/inst_mem_fetch.md
# inst_mem_fetch

Parametrised instruction memory for the pipelined RISC-V core's IF stage. It replaces the fixed 64-word combinational ROM with a registered, byte-addressed fetch port that uses a valid/ready handshake, honours flush and back-pressure, and reports faults. A word-wide programming port loads the program at run time, so no hard-coded initial block is needed.

## Interface
- `DEPTH`, default 64: memory size in 32-bit words; a power of two, at least 2.
- `ADDR_W`, default 32: width of the fetch byte address (the PC).
- `NOP_INSTR`, default 32'h00000013: word returned on a fault and after reset (`addi x0,x0,0`).
- `IDX_W`, derived as clog2(DEPTH): width of the word index.

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: a fetch request is present.
- `req_ready` output 1: the block can accept a request this cycle (combinational).
- `req_addr` input ADDR_W: fetch byte address (PC).
- `resp_valid` output 1: response register holds a valid instruction.
- `resp_ready` input 1: the decode stage takes the response this cycle.
- `resp_inst` output 32: fetched instruction.
- `resp_addr` output ADDR_W: byte address that produced `resp_inst`.
- `resp_fault` output 1: the request was misaligned or out of range.
- `flush` input 1: discard the held response (branch or jump redirect).
- `prog_en` input 1: programming mode; fetch is blocked.
- `prog_we` input 1: write strobe, qualified by `prog_en`.
- `prog_addr` input IDX_W: word index to write.
- `prog_data` input 32: word to write.

## Operation
- **Word index.** The index is `req_addr[IDX_W+1:2]`.
- **Range check.** An address is in range when `req_addr[ADDR_W-1:IDX_W+2]` is all zero.
- **Misalignment.** A request is misaligned when `req_addr[1:0]` is not 0.
- **Ready.** `req_ready = !rst && !prog_en && (!resp_valid || resp_ready || flush)`.
- **Accept.** A request is accepted when `req_valid && req_ready`. On the next edge the block loads:
  - `resp_valid` = 1;
  - `resp_addr` = `req_addr`;
  - `resp_inst` = mem[index] when the request is aligned and in range, otherwise `NOP_INSTR`;
  - `resp_fault` = 1 when the request is misaligned or out of range.
- **Hold.** While `resp_valid && !resp_ready && !flush`, every `resp_*` output stays bit-stable.
- **Consume.** When `resp_valid && resp_ready` and no new request is accepted, `resp_valid` clears on the next edge.
- **Flush.**
  - Flush with no accept: `resp_valid` clears on the next edge.
  - Flush together with an accept: the new request's response loads normally, because the redirect target wins.
  - `resp_inst`, `resp_addr` and `resp_fault` keep their last values while `resp_valid` = 0.
- **Programming.**
  - When `prog_en && prog_we` and `prog_addr < DEPTH`, mem[`prog_addr`] is written at the edge.
  - A write to an index at or above DEPTH is ignored (only possible when DEPTH is not a power of two).
  - A response that is already held stays valid and unchanged during programming.
  - A read can never collide with a write, because `req_ready` = 0 while `prog_en` = 1.
- **Memory contents.** All words initialise to `NOP_INSTR` at time zero. Reset does not clear memory; contents persist across `rst`.
- **Reset.** `rst` overrides everything, including a handshake in flight. After the edge:
  - `resp_valid` = 0, `resp_inst` = `NOP_INSTR`, `resp_addr` = 0, `resp_fault` = 0.
  - A `prog_we` asserted in the same cycle as `rst` still writes memory.

## Timing
- **Read latency.** One cycle from accept to `resp_valid`.
- **Throughput.** One fetch per cycle while `resp_ready` = 1.
- **Ready path.** `req_ready` is combinational from `resp_valid`, `resp_ready`, `flush`, `prog_en` and `rst`. There is no combinational path from `req_addr` or `req_valid` to `req_ready`.
- **Write-to-fetch.** A fetch accepted in the cycle after the write returns the new data.
- **Leaving programming mode.** The first fetch can be accepted in the cycle `prog_en` deasserts.
- **Back-to-back flushes.** Each one clears independently; there is no residual state.

## Test plan
- **Program then sequential fetch.**
  - Stimulus: write words 0..3 = 0x00C00093, 0x00100113, 0x002081B3, 0x40208233, then fetch 0x0, 0x4, 0x8, 0xC with `resp_ready` = 1.
  - Required: four consecutive `resp_valid` cycles, each one cycle after its request, with matching data, `resp_addr` equal to the request address, and `resp_fault` = 0.
- **Back-pressure.**
  - Stimulus: fetch 0x4, then hold `resp_ready` = 0 for 3 cycles with `req_valid` = 1 at 0x8.
  - Required: `req_ready` = 0, the 0x4 response stays stable, and 0x8 is accepted in the cycle `resp_ready` rises, with its response one cycle later.
- **Faults** (DEPTH = 64).
  - Stimulus: fetch 0x2, then 0x100.
  - Required: both responses have `resp_fault` = 1 and `resp_inst` = 0x00000013; `resp_addr` = 0x2 and 0x100 respectively.
- **Flush.**
  - Stimulus: stall a response for 0x8, then assert `flush` with a request at 0x20.
  - Required: the 0x8 response is dropped and the next response is for 0x20. A flush alone clears `resp_valid` after one edge.
- **Programming mode.**
  - Stimulus: assert `prog_en` while a response is held, write word 2 = 0xDEADBEEF, then deassert and fetch 0x8.
  - Required: `req_ready` = 0 throughout programming, the held response is unchanged, and the fetch of 0x8 returns 0xDEADBEEF.
- **Reset mid-stream.**
  - Stimulus: assert `rst` while `resp_valid` = 1 and `resp_ready` = 0.
  - Required: after the edge, `resp_valid` = 0, `resp_inst` = 0x00000013 and `resp_addr` = 0; a later fetch of 0x0 still returns the programmed word.
